// File: rtl/mux_pkg.sv
// mux_pkg: tree sizing and channel packing helpers for pipe_mux_n
package mux_pkg;
  function automatic int log2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction
  function automatic int levels(input int n);
    return log2(n);
  endfunction
  function automatic int stages(input int n, input int reg_every);
    return (levels(n) + reg_every - 1) / reg_every;
  endfunction
  function automatic int ch_off(input int k, input int width);
    return k * width;
  endfunction
endpackage

// File: rtl/mux2.sv
// mux2: vectorised 2:1 mux leaf, s=0 selects a
module mux2 #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  output logic [WIDTH-1:0] y
);
  assign y = s ? b : a;
endmodule

// File: rtl/pipe_mux_stage.sv
// pipe_mux_stage: one group of mux tree levels plus its pipeline register
module pipe_mux_stage #(
  parameter int WIDTH = 32,
  parameter int IN_CH = 16,
  parameter int LVLS  = 1,
  parameter int CHW   = 4,
  parameter int BASE  = 0
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               adv,
  input  logic                               v_in,
  input  logic [CHW-1:0]                     ch_in,
  input  logic [IN_CH*WIDTH-1:0]             d,
  output logic                               v,
  output logic [CHW-1:0]                     ch,
  output logic [(IN_CH>>LVLS)*WIDTH-1:0]     q
);
  localparam int OUT_CH = IN_CH >> LVLS;
  logic [OUT_CH*WIDTH-1:0] t;
  // level l halves the channel count using select bit BASE+l of the carried index
  for (genvar l = 0; l < LVLS; l++) begin : g_l
    localparam int M = IN_CH >> (l + 1);
    logic [2*M*WIDTH-1:0] x;
    logic [M*WIDTH-1:0]   o;
    if (l == 0) begin : g_first
      assign x = d;
    end else begin : g_next
      assign x = g_l[l-1].o;
    end
    for (genvar k = 0; k < M; k++) begin : g_k
      mux2 #(.WIDTH(WIDTH)) u_mux (
        .a(x[2*k*WIDTH +: WIDTH]),
        .b(x[(2*k+1)*WIDTH +: WIDTH]),
        .s(ch_in[BASE+l]),
        .y(o[k*WIDTH +: WIDTH])
      );
    end
  end
  assign t = g_l[LVLS-1].o;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v  <= 1'b0;
      ch <= '0;
      q  <= '0;
    end else if (adv) begin
      v  <= v_in;
      ch <= ch_in;
      q  <= t;
    end
  end
endmodule

// File: rtl/pipe_mux_n.sv
// pipe_mux_n: pipelined N:1 word mux with valid/ready flow and round-robin scan
module pipe_mux_n
  import mux_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int N         = 16,
  parameter int REG_EVERY = 1,
  localparam int LG       = log2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode_rr,
  input  logic [LG-1:0]      sel,
  input  logic [N*WIDTH-1:0] src,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   result,
  output logic [LG-1:0]      result_ch,
  output logic               out_valid,
  input  logic               out_ready
);
  localparam int S = stages(N, REG_EVERY);
  logic [S-1:0]  v;
  logic [S-1:0]  adv;
  logic [LG-1:0] ch [S];
  logic [LG-1:0] rr_ptr;
  logic [LG-1:0] eff_sel;
  assign eff_sel = mode_rr ? rr_ptr : sel;
  // stage i can move unless it and every stage after it is full while the consumer stalls
  for (genvar i = 0; i < S; i++) begin : g_adv
    assign adv[i] = out_ready || !(&v[S-1:i]);
  end
  assign in_ready  = adv[0];
  assign out_valid = v[S-1];
  assign result_ch = ch[S-1];
  always_ff @(posedge clk) begin
    if (!rst_n) rr_ptr <= '0;
    else if (in_valid && in_ready && mode_rr) rr_ptr <= rr_ptr + 1'b1;
  end
  for (genvar s = 0; s < S; s++) begin : g_s
    localparam int BASE = s * REG_EVERY;
    localparam int LV   = (LG - BASE < REG_EVERY) ? LG - BASE : REG_EVERY;
    localparam int IC   = N >> BASE;
    logic [IC*WIDTH-1:0]       d;
    logic [(IC>>LV)*WIDTH-1:0] q;
    logic [LG-1:0]             ci;
    logic                      vi;
    if (s == 0) begin : g_head
      assign d  = src;
      assign ci = eff_sel;
      assign vi = in_valid;
    end else begin : g_tail
      assign d  = g_s[s-1].q;
      assign ci = ch[s-1];
      assign vi = v[s-1];
    end
    pipe_mux_stage #(
      .WIDTH(WIDTH),
      .IN_CH(IC),
      .LVLS(LV),
      .CHW(LG),
      .BASE(BASE)
    ) u_stage (
      .clk(clk),
      .rst_n(rst_n),
      .adv(adv[s]),
      .v_in(vi),
      .ch_in(ci),
      .d(d),
      .v(v[s]),
      .ch(ch[s]),
      .q(q)
    );
  end
  assign result = g_s[S-1].q;
endmodule

// File: tb/tb_pipe_mux_n.sv
// tb_pipe_mux_n: scoreboard bench driving three configurations with shared stimulus
module tb_pipe_mux_n;
  localparam int NN [3] = '{16, 2, 16};
  localparam int RR [3] = '{1, 1, 3};
  localparam int LAT [3] = '{3, 0, 1};
  logic          clk;
  logic          rst_n;
  logic          mode_rr;
  logic [3:0]    sel;
  logic [511:0]  src;
  logic          in_valid;
  logic          out_ready;
  logic [2:0]    ir;
  logic [2:0]    ov;
  logic [31:0]   res [3];
  logic [3:0]    rch [3];
  int tests = 0;
  int fails = 0;
  logic [35:0] sb [3][$];
  int rrm [3];
  int acc [3];
  int a0 [3];
  logic [2:0]  stall_q;
  logic [31:0] hold_r [3];
  logic [3:0]  hold_c [3];
  logic [3:0]  log0 [$];
  int rises0, hi0;
  logic prev0;
  for (genvar g = 0; g < 3; g++) begin : g_d
    localparam int LGG = $clog2(NN[g]);
    logic [LGG-1:0] c;
    pipe_mux_n #(.WIDTH(32), .N(NN[g]), .REG_EVERY(RR[g])) u_dut (
      .clk(clk),
      .rst_n(rst_n),
      .mode_rr(mode_rr),
      .sel(sel[LGG-1:0]),
      .src(src[NN[g]*32-1:0]),
      .in_valid(in_valid),
      .in_ready(ir[g]),
      .result(res[g]),
      .result_ch(c),
      .out_valid(ov[g]),
      .out_ready(out_ready)
    );
    assign rch[g] = 4'(c);
  end
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drain();
    logic busy;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    busy = 1'b1;
    for (int i = 0; i < 60 && busy; i++) begin
      tick();
      busy = (sb[0].size() + sb[1].size() + sb[2].size() != 0) || (ov != 3'b000);
    end
    chk("drain", 64'(busy), 64'd0);
  endtask
  // scoreboard and stall monitor; inputs only change just after posedge, so negedge sees the next edge's handshake
  always @(negedge clk) begin
    logic [35:0] e;
    int c;
    for (int g = 0; g < 3; g++) begin
      if (stall_q[g]) chk($sformatf("stall%0d", g), {ov[g], rch[g], res[g]}, {1'b1, hold_c[g], hold_r[g]});
      if (!rst_n) begin
        sb[g].delete();
        rrm[g] = 0;
        stall_q[g] = 1'b0;
      end else begin
        if (ov[g] && out_ready) begin
          if (sb[g].size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected%0d: got ch %0d data %0h expected no word", g, rch[g], res[g]);
          end else begin
            e = sb[g].pop_front();
            chk($sformatf("out%0d", g), {rch[g], res[g]}, e);
          end
          if (g == 0) log0.push_back(rch[0]);
        end
        if (in_valid && ir[g]) begin
          c = mode_rr ? rrm[g] : int'(sel) % NN[g];
          if (mode_rr) rrm[g] = (rrm[g] + 1) % NN[g];
          sb[g].push_back({4'(c), src[mux_pkg::ch_off(c, 32) +: 32]});
          acc[g]++;
        end
        stall_q[g] = ov[g] && !out_ready;
        hold_r[g] = res[g];
        hold_c[g] = rch[g];
      end
    end
    if (ov[0] && !prev0) rises0++;
    if (ov[0]) hi0++;
    prev0 = ov[0];
  end
  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    stall_q = '0;
    prev0 = 1'b0;
    for (int g = 0; g < 3; g++) begin
      rrm[g] = 0;
      acc[g] = 0;
    end
    rst_n = 1'b0; mode_rr = 1'b0; sel = '0; src = '0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int g = 0; g < 3; g++)
      chk($sformatf("reset%0d", g), {ov[g], ir[g], rch[g], res[g]}, {1'b0, 1'b1, 4'd0, 32'd0});
    for (int k = 0; k < 16; k++) src[k*32 +: 32] = 32'hA000_0000 + 32'(k);
    tick();
    sel = 4'd5;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int e = 0; e < 5; e++) begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) chk($sformatf("lat%0d_e%0d", g, e), 64'(ov[g]), 64'(e == LAT[g]));
    end
    drain();
    log0.delete();
    rises0 = 0;
    hi0 = 0;
    for (int i = 0; i < 16; i++) begin
      sel = 4'(i);
      in_valid = 1'b1;
      tick();
    end
    drain();
    chk("sweep_rises", 64'(rises0), 64'd1);
    chk("sweep_high", 64'(hi0), 64'd16);
    chk("sweep_len", 64'(log0.size()), 64'd16);
    for (int i = 0; i < 16 && i < log0.size(); i++) chk($sformatf("sweep_ch%0d", i), 64'(log0[i]), 64'(i));
    out_ready = 1'b0;
    for (int g = 0; g < 3; g++) a0[g] = acc[g];
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      sel = 4'($urandom_range(15));
      tick();
    end
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("bp_accepts%0d", g), 64'(acc[g] - a0[g]), 64'(LAT[g] + 1));
      chk($sformatf("bp_ready%0d", g), 64'(ir[g]), 64'd0);
    end
    drain();
    log0.delete();
    mode_rr = 1'b1;
    in_valid = 1'b1;
    repeat (18) tick();
    mode_rr = 1'b0;
    sel = 4'd9;
    tick();
    mode_rr = 1'b1;
    tick();
    mode_rr = 1'b0;
    drain();
    chk("rr_len", 64'(log0.size()), 64'd20);
    for (int i = 0; i < 20 && i < log0.size(); i++)
      chk($sformatf("rr_ch%0d", i), 64'(log0[i]), i < 18 ? 64'(i % 16) : (i == 18 ? 64'd9 : 64'd2));
    for (int i = 0; i < 10000; i++) begin
      in_valid = $urandom_range(3) != 0;
      out_ready = $urandom_range(9) < 7;
      sel = 4'($urandom_range(15));
      if ($urandom_range(15) == 0) mode_rr = ~mode_rr;
      for (int k = 0; k < 16; k++) src[k*32 +: 32] = $urandom;
      tick();
    end
    mode_rr = 1'b0;
    drain();
    out_ready = 1'b0;
    in_valid = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    for (int g = 0; g < 3; g++)
      chk($sformatf("midrst%0d", g), {ov[g], rch[g], res[g]}, {1'b0, 4'd0, 32'd0});
    tick();
    out_ready = 1'b1;
    repeat (5) tick();
    for (int g = 0; g < 3; g++) chk($sformatf("nostale%0d", g), 64'(ov[g]), 64'd0);
    log0.delete();
    mode_rr = 1'b1;
    in_valid = 1'b1;
    tick();
    mode_rr = 1'b0;
    drain();
    chk("rst_rr_len", 64'(log0.size()), 64'd1);
    if (log0.size() > 0) chk("rst_rr_ch", 64'(log0[0]), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
